reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_if.sv | 66 ++++++
 rtl/reorder_buffer.sv | 197 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer interface: allocation, CDB, operand lookup, commit and store signals.
// The master side is the core pipeline; the slave side is the reorder buffer.
interface reorder_buffer_if #(
    parameter int ROB_TAG_LEN = 4,
    parameter int XLEN        = 32
);
    // Allocation from the issue stage
    logic                   alloc_enable;
    logic [4:0]             alloc_dest_reg;
    logic                   alloc_wr_mem;
    logic [XLEN-1:0]        alloc_value_in;
    logic                   alloc_value_in_valid;
    logic [ROB_TAG_LEN-1:0] alloc_store_dep;
    logic [2:0]             alloc_mem_size;
    logic                   alloc_halt;
    logic [ROB_TAG_LEN-1:0] alloc_tag;
    logic                   rob_full;

    // Pipeline flush
    logic                   squash;

    // Common data bus
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;

    // Operand lookup
    logic [ROB_TAG_LEN-1:0] rs1_rob_tag;
    logic [ROB_TAG_LEN-1:0] rs2_rob_tag;
    logic [XLEN-1:0]        rs1_read_rob_value;
    logic [XLEN-1:0]        rs2_read_rob_value;
    logic                   rs1_rob_ready;
    logic                   rs2_rob_ready;

    // Commit
    logic                   wb_reg_wr_en_out;
    logic [4:0]             wb_reg_wr_idx_out;
    logic [XLEN-1:0]        wb_reg_wr_data_out;
    logic                   commit_valid;
    logic [ROB_TAG_LEN-1:0] commit_tag;
    logic                   store_en;
    logic [XLEN-1:0]        store_addr;
    logic [XLEN-1:0]        store_data;
    logic [2:0]             store_size;
    logic                   halt_out;

    modport master (
        output alloc_enable, alloc_dest_reg, alloc_wr_mem, alloc_value_in,
               alloc_value_in_valid, alloc_store_dep, alloc_mem_size, alloc_halt,
               squash, cdb_valid, cdb_tag, cdb_value, rs1_rob_tag, rs2_rob_tag,
        input  alloc_tag, rob_full, rs1_read_rob_value, rs2_read_rob_value,
               rs1_rob_ready, rs2_rob_ready, wb_reg_wr_en_out, wb_reg_wr_idx_out,
               wb_reg_wr_data_out, commit_valid, commit_tag, store_en, store_addr,
               store_data, store_size, halt_out
    );

    modport slave (
        input  alloc_enable, alloc_dest_reg, alloc_wr_mem, alloc_value_in,
               alloc_value_in_valid, alloc_store_dep, alloc_mem_size, alloc_halt,
               squash, cdb_valid, cdb_tag, cdb_value, rs1_rob_tag, rs2_rob_tag,
        output alloc_tag, rob_full, rs1_read_rob_value, rs2_read_rob_value,
               rs1_rob_ready, rs2_rob_ready, wb_reg_wr_en_out, wb_reg_wr_idx_out,
               wb_reg_wr_data_out, commit_valid, commit_tag, store_en, store_addr,
               store_data, store_size, halt_out
    );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular FIFO of in-flight instructions that retires results in
// program order. Entry i carries tag i+1; tag 0 means "no ROB producer".
module reorder_buffer #(
    parameter int ROB_SIZE    = 8,
    parameter int ROB_TAG_LEN = 4,
    parameter int XLEN        = 32
) (
    input logic             clock,
    input logic             reset,
    reorder_buffer_if.slave rob
);
    localparam int PTR_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int CNT_W = $clog2(ROB_SIZE + 1);

    typedef struct packed {
        logic                   valid;
        logic                   ready;       // result, or store address, is present
        logic                   is_store;
        logic                   is_halt;
        logic [4:0]             dest;
        logic [2:0]             mem_size;
        logic [XLEN-1:0]        value;       // result, or store effective address
        logic                   data_valid;  // store data present
        logic [XLEN-1:0]        data;
        logic [ROB_TAG_LEN-1:0] store_dep;
    } entry_t;

    entry_t            entries_q [ROB_SIZE];
    entry_t            entries_d [ROB_SIZE];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              halt_q, halt_d;

    entry_t            head_e;
    entry_t            alloc_entry;
    logic              full;
    logic              alloc_fire;
    logic              commit_fire;
    logic              wb_fire;
    logic              store_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [ROB_TAG_LEN-1:0] tag_of(input int idx);
        return ROB_TAG_LEN'(idx + 1);
    endfunction

    assign head_e      = entries_q[head_q];
    assign full        = (count_q == CNT_W'(ROB_SIZE));
    assign alloc_fire  = rob.alloc_enable && !full && !halt_q && !rob.squash;
    assign commit_fire = head_e.valid && head_e.ready &&
                         (!head_e.is_store || head_e.data_valid) &&
                         !rob.squash && !halt_q;
    assign wb_fire     = commit_fire && !head_e.is_store && !head_e.is_halt &&
                         (head_e.dest != 5'd0);
    assign store_fire  = commit_fire && head_e.is_store;

    // Build the entry written at the tail, capturing store data from the CDB if it arrives now.
    always_comb begin
        // NOTE: every field gets a default before any condition, so no path leaves a
        // variable unassigned and no latch is inferred.
        alloc_entry           = '0;
        alloc_entry.valid     = 1'b1;
        alloc_entry.ready     = rob.alloc_halt;
        alloc_entry.is_store  = rob.alloc_wr_mem;
        alloc_entry.is_halt   = rob.alloc_halt;
        alloc_entry.dest      = rob.alloc_dest_reg;
        alloc_entry.mem_size  = rob.alloc_mem_size;
        alloc_entry.store_dep = rob.alloc_store_dep;
        if (rob.alloc_wr_mem) begin
            if (rob.alloc_value_in_valid) begin
                alloc_entry.data       = rob.alloc_value_in;
                alloc_entry.data_valid = 1'b1;
            end else if (rob.cdb_valid && (rob.alloc_store_dep != '0) &&
                         (rob.alloc_store_dep == rob.cdb_tag)) begin
                alloc_entry.data       = rob.cdb_value;
                alloc_entry.data_valid = 1'b1;
            end
        end
    end

    // Next state: squash wins; otherwise apply CDB writeback, head retire and tail allocate.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        halt_d    = halt_q;
        if (rob.squash) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (rob.cdb_valid) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (entries_q[i].valid && (rob.cdb_tag == tag_of(i))) begin
                        entries_d[i].value = rob.cdb_value;
                        entries_d[i].ready = 1'b1;
                    end
                    if (entries_q[i].valid && entries_q[i].is_store &&
                        !entries_q[i].data_valid &&
                        (entries_q[i].store_dep == rob.cdb_tag)) begin
                        entries_d[i].data       = rob.cdb_value;
                        entries_d[i].data_valid = 1'b1;
                    end
                end
            end
            if (commit_fire) begin
                entries_d[head_q] = '0;
                head_d            = ptr_inc(head_q);
                if (head_e.is_halt) begin
                    halt_d = 1'b1;
                end
            end
            if (alloc_fire) begin
                entries_d[tail_q] = alloc_entry;
                tail_d            = ptr_inc(tail_q);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register: entries, pointers, occupancy and sticky halt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the entry array is cleared in full, not only its valid bits, so the
            // read ports and commit outputs show zeros straight out of reset.
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every register sample pre-edge values;
            // the combinational blocks above use blocking assignments.
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            halt_q    <= halt_d;
        end
    end

    // Allocation status and commit outputs, driven straight from the head entry.
    always_comb begin
        rob.alloc_tag          = tag_of(int'(tail_q));
        rob.rob_full           = full;
        rob.halt_out           = halt_q;
        rob.commit_valid       = commit_fire;
        rob.commit_tag         = commit_fire ? tag_of(int'(head_q)) : '0;
        rob.wb_reg_wr_en_out   = wb_fire;
        rob.wb_reg_wr_idx_out  = wb_fire ? head_e.dest : 5'd0;
        rob.wb_reg_wr_data_out = wb_fire ? head_e.value : '0;
        rob.store_en           = store_fire;
        rob.store_addr         = store_fire ? head_e.value : '0;
        rob.store_data         = store_fire ? head_e.data : '0;
        rob.store_size         = store_fire ? head_e.mem_size : 3'd0;
    end

    // Operand lookup with same-cycle CDB bypass; tag 0 never matches an entry.
    always_comb begin
        rob.rs1_read_rob_value = '0;
        rob.rs1_rob_ready      = 1'b0;
        rob.rs2_read_rob_value = '0;
        rob.rs2_rob_ready      = 1'b0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (rob.rs1_rob_tag == tag_of(i)) begin
                rob.rs1_read_rob_value = entries_q[i].value;
                rob.rs1_rob_ready      = entries_q[i].valid && entries_q[i].ready;
            end
            if (rob.rs2_rob_tag == tag_of(i)) begin
                rob.rs2_read_rob_value = entries_q[i].value;
                rob.rs2_rob_ready      = entries_q[i].valid && entries_q[i].ready;
            end
        end
        if (rob.cdb_valid && (rob.rs1_rob_tag != '0) && (rob.rs1_rob_tag == rob.cdb_tag)) begin
            rob.rs1_read_rob_value = rob.cdb_value;
            rob.rs1_rob_ready      = 1'b1;
        end
        if (rob.cdb_valid && (rob.rs2_rob_tag != '0) && (rob.rs2_rob_tag == rob.cdb_tag)) begin
            rob.rs2_read_rob_value = rob.cdb_value;
            rob.rs2_rob_ready      = 1'b1;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a queue-based program-order model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_reorder_buffer;
    localparam int ROB_SIZE = 8;
    localparam int TAG_W    = 4;
    localparam int XLEN     = 32;

    logic clock;
    logic reset;

    reorder_buffer_if #(.ROB_TAG_LEN(TAG_W), .XLEN(XLEN)) bus ();

    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ROB_TAG_LEN(TAG_W), .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .rob   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: program-order queue ----------------
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       dest;
        bit               st;
        bit               halt;
        bit               rdy;
        logic [31:0]      val;
        bit               dv;
        logic [31:0]      data;
        logic [TAG_W-1:0] dep;
        logic [2:0]       size;
    } m_entry_t;

    m_entry_t mq[$];
    int       m_tail_tag = 1;
    bit       m_halt     = 1'b0;

    function automatic bit model_commit();
        if (mq.size() == 0 || bus.squash || m_halt) return 1'b0;
        return mq[0].rdy && (!mq[0].st || mq[0].dv);
    endfunction

    function automatic void model_read(input logic [TAG_W-1:0] tag,
                                       output logic [31:0] val, output logic rdy);
        val = '0;
        rdy = 1'b0;
        if (tag != 0) begin
            if (bus.cdb_valid && bus.cdb_tag == tag) begin
                val = bus.cdb_value;
                rdy = 1'b1;
            end else begin
                foreach (mq[k]) begin
                    if (mq[k].tag == tag) begin
                        val = mq[k].val;
                        rdy = mq[k].rdy;
                    end
                end
            end
        end
    endfunction

    task automatic model_step();
        bit       do_commit;
        bit       do_alloc;
        m_entry_t ne;
        if (reset) begin
            mq.delete();
            m_tail_tag = 1;
            m_halt     = 1'b0;
        end else if (bus.squash) begin
            mq.delete();
            m_tail_tag = 1;
        end else begin
            do_commit = model_commit();
            do_alloc  = bus.alloc_enable && (mq.size() < ROB_SIZE) && !m_halt;
            if (bus.cdb_valid) begin
                foreach (mq[k]) begin
                    if (mq[k].tag == bus.cdb_tag) begin
                        mq[k].val = bus.cdb_value;
                        mq[k].rdy = 1'b1;
                    end
                    if (mq[k].st && !mq[k].dv && mq[k].dep == bus.cdb_tag) begin
                        mq[k].data = bus.cdb_value;
                        mq[k].dv   = 1'b1;
                    end
                end
            end
            if (do_commit) begin
                if (mq[0].halt) m_halt = 1'b1;
                void'(mq.pop_front());
            end
            if (do_alloc) begin
                ne.tag  = TAG_W'(m_tail_tag);
                ne.dest = bus.alloc_dest_reg;
                ne.st   = bus.alloc_wr_mem;
                ne.halt = bus.alloc_halt;
                ne.rdy  = bus.alloc_halt;
                ne.val  = '0;
                ne.dep  = bus.alloc_store_dep;
                ne.size = bus.alloc_mem_size;
                ne.dv   = 1'b0;
                ne.data = '0;
                if (bus.alloc_wr_mem && bus.alloc_value_in_valid) begin
                    ne.dv   = 1'b1;
                    ne.data = bus.alloc_value_in;
                end else if (bus.alloc_wr_mem && bus.cdb_valid && bus.alloc_store_dep != 0 &&
                             bus.alloc_store_dep == bus.cdb_tag) begin
                    ne.dv   = 1'b1;
                    ne.data = bus.cdb_value;
                end
                mq.push_back(ne);
                m_tail_tag = (m_tail_tag == ROB_SIZE) ? 1 : m_tail_tag + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            model_step();
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    bit          c_commit;
    bit          c_wb;
    bit          c_st;
    logic [31:0] c_val;
    logic        c_rdy;

    always @(negedge clock) begin
        if (!reset) begin
            c_commit = model_commit();
            c_wb     = c_commit && !mq[0].st && !mq[0].halt && mq[0].dest != 0;
            c_st     = c_commit && mq[0].st;
            check("cmp alloc_tag", 32'(bus.alloc_tag), 32'(m_tail_tag));
            check("cmp rob_full", 32'(bus.rob_full), 32'(mq.size() == ROB_SIZE));
            check("cmp halt_out", 32'(bus.halt_out), 32'(m_halt));
            check("cmp commit_valid", 32'(bus.commit_valid), 32'(c_commit));
            check("cmp wb_en", 32'(bus.wb_reg_wr_en_out), 32'(c_wb));
            check("cmp store_en", 32'(bus.store_en), 32'(c_st));
            if (c_commit) check("cmp commit_tag", 32'(bus.commit_tag), 32'(mq[0].tag));
            if (c_wb) begin
                check("cmp wb_idx", 32'(bus.wb_reg_wr_idx_out), 32'(mq[0].dest));
                check("cmp wb_data", bus.wb_reg_wr_data_out, mq[0].val);
            end
            if (c_st) begin
                check("cmp store_addr", bus.store_addr, mq[0].val);
                check("cmp store_data", bus.store_data, mq[0].data);
                check("cmp store_size", 32'(bus.store_size), 32'(mq[0].size));
            end
            model_read(bus.rs1_rob_tag, c_val, c_rdy);
            check("cmp rs1_ready", 32'(bus.rs1_rob_ready), 32'(c_rdy));
            if (c_rdy) check("cmp rs1_value", bus.rs1_read_rob_value, c_val);
            model_read(bus.rs2_rob_tag, c_val, c_rdy);
            check("cmp rs2_ready", 32'(bus.rs2_rob_ready), 32'(c_rdy));
            if (c_rdy) check("cmp rs2_value", bus.rs2_read_rob_value, c_val);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic defaults();
        bus.alloc_enable         = 1'b0;
        bus.alloc_dest_reg       = '0;
        bus.alloc_wr_mem         = 1'b0;
        bus.alloc_value_in       = '0;
        bus.alloc_value_in_valid = 1'b0;
        bus.alloc_store_dep      = '0;
        bus.alloc_mem_size       = '0;
        bus.alloc_halt           = 1'b0;
        bus.squash               = 1'b0;
        bus.cdb_valid            = 1'b0;
        bus.cdb_tag              = '0;
        bus.cdb_value            = '0;
        bus.rs1_rob_tag          = '0;
        bus.rs2_rob_tag          = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        defaults();
    endtask

    task automatic alloc(input logic [4:0] dest);
        bus.alloc_enable   = 1'b1;
        bus.alloc_dest_reg = dest;
    endtask

    task automatic alloc_store(input logic vv, input logic [31:0] v,
                               input logic [TAG_W-1:0] dep, input logic [2:0] size);
        bus.alloc_enable         = 1'b1;
        bus.alloc_wr_mem         = 1'b1;
        bus.alloc_value_in_valid = vv;
        bus.alloc_value_in       = v;
        bus.alloc_store_dep      = dep;
        bus.alloc_mem_size       = size;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = v;
    endtask

    task automatic do_squash();
        bus.squash = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1;
        defaults();
        @(negedge clock);
        check("reset alloc_tag", 32'(bus.alloc_tag), 32'd1);
        check("reset rob_full", 32'(bus.rob_full), 32'd0);
        check("reset commit_valid", 32'(bus.commit_valid), 32'd0);
        check("reset halt_out", 32'(bus.halt_out), 32'd0);
        check("reset wb_en", 32'(bus.wb_reg_wr_en_out), 32'd0);
        check("reset store_en", 32'(bus.store_en), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single ALU op: alloc x5, CDB 0x2A, commit next cycle.
        alloc(5'd5);
        @(negedge clock);
        check("t1 alloc_tag", 32'(bus.alloc_tag), 32'd1);
        tick();
        cdb(4'd1, 32'h2A);
        @(negedge clock);
        check("t1 no early commit", 32'(bus.commit_valid), 32'd0);
        tick();
        @(negedge clock);
        check("t1 wb_en", 32'(bus.wb_reg_wr_en_out), 32'd1);
        check("t1 wb_idx", 32'(bus.wb_reg_wr_idx_out), 32'd5);
        check("t1 wb_data", bus.wb_reg_wr_data_out, 32'h2A);
        check("t1 commit_tag", 32'(bus.commit_tag), 32'd1);
        tick();
        @(negedge clock);
        check("t1 empty no commit", 32'(bus.commit_valid), 32'd0);
        check("t1 alloc_tag after", 32'(bus.alloc_tag), 32'd2);

        // Fill to full, drop extra allocs, wrap the tail.
        do_squash();
        for (int i = 0; i < ROB_SIZE; i++) begin
            alloc(5'(i + 1));
            tick();
        end
        @(negedge clock);
        check("t2 full", 32'(bus.rob_full), 32'd1);
        check("t2 wrapped tag", 32'(bus.alloc_tag), 32'd1);
        alloc(5'd9);
        cdb(4'd1, 32'h11);
        tick();
        alloc(5'd10);
        @(negedge clock);
        check("t2 commit while full", 32'(bus.commit_valid), 32'd1);
        check("t2 commit tag", 32'(bus.commit_tag), 32'd1);
        check("t2 still full", 32'(bus.rob_full), 32'd1);
        tick();
        @(negedge clock);
        check("t2 not full", 32'(bus.rob_full), 32'd0);
        check("t2 alloc_tag wrap", 32'(bus.alloc_tag), 32'd1);
        alloc(5'd11);
        tick();
        @(negedge clock);
        check("t2 refull", 32'(bus.rob_full), 32'd1);
        check("t2 alloc_tag next", 32'(bus.alloc_tag), 32'd2);

        // Out-of-order completion, in-order commit.
        do_squash();
        for (int i = 1; i <= 3; i++) begin
            alloc(5'(i));
            tick();
        end
        cdb(4'd3, 32'h33);
        tick();
        cdb(4'd2, 32'h22);
        @(negedge clock);
        check("t3 head blocks", 32'(bus.commit_valid), 32'd0);
        tick();
        cdb(4'd1, 32'h11);
        tick();
        @(negedge clock);
        check("t3 commit tag1", 32'(bus.commit_tag), 32'd1);
        check("t3 data tag1", bus.wb_reg_wr_data_out, 32'h11);
        tick();
        @(negedge clock);
        check("t3 commit tag2", 32'(bus.commit_tag), 32'd2);
        check("t3 data tag2", bus.wb_reg_wr_data_out, 32'h22);
        tick();
        @(negedge clock);
        check("t3 commit tag3", 32'(bus.commit_tag), 32'd3);
        check("t3 data tag3", bus.wb_reg_wr_data_out, 32'h33);
        tick();

        // Store whose data comes from a later CDB broadcast.
        do_squash();
        alloc(5'd7);
        tick();
        alloc_store(1'b0, 32'h0, 4'd1, 3'd2);
        tick();
        cdb(4'd2, 32'h100);
        tick();
        cdb(4'd1, 32'hDEAD);
        tick();
        @(negedge clock);
        check("t4 wb_idx", 32'(bus.wb_reg_wr_idx_out), 32'd7);
        check("t4 wb_data", bus.wb_reg_wr_data_out, 32'hDEAD);
        check("t4 no store yet", 32'(bus.store_en), 32'd0);
        tick();
        @(negedge clock);
        check("t4 store_en", 32'(bus.store_en), 32'd1);
        check("t4 store_addr", bus.store_addr, 32'h100);
        check("t4 store_data", bus.store_data, 32'hDEAD);
        check("t4 store_size", 32'(bus.store_size), 32'd2);
        check("t4 store no wb", 32'(bus.wb_reg_wr_en_out), 32'd0);
        tick();

        // Store data captured from the CDB in its own allocation cycle; then immediate data.
        do_squash();
        alloc(5'd3);
        tick();
        cdb(4'd1, 32'h77);
        alloc_store(1'b0, 32'h0, 4'd1, 3'd0);
        tick();
        cdb(4'd2, 32'h200);
        @(negedge clock);
        check("t5 wb_data", bus.wb_reg_wr_data_out, 32'h77);
        tick();
        @(negedge clock);
        check("t5 store_addr", bus.store_addr, 32'h200);
        check("t5 store_data", bus.store_data, 32'h77);
        tick();
        alloc_store(1'b1, 32'hBEEF, 4'd0, 3'd1);
        tick();
        cdb(4'd3, 32'h300);
        tick();
        @(negedge clock);
        check("t5 imm store_data", bus.store_data, 32'hBEEF);
        check("t5 imm store_size", 32'(bus.store_size), 32'd1);
        check("t5 imm commit_tag", 32'(bus.commit_tag), 32'd3);
        tick();

        // Operand lookup with CDB bypass.
        do_squash();
        for (int i = 1; i <= 3; i++) begin
            alloc(5'(i));
            tick();
        end
        bus.rs1_rob_tag = 4'd3;
        bus.rs2_rob_tag = 4'd0;
        cdb(4'd3, 32'h55);
        @(negedge clock);
        check("t6 bypass value", bus.rs1_read_rob_value, 32'h55);
        check("t6 bypass ready", 32'(bus.rs1_rob_ready), 32'd1);
        check("t6 tag0 value", bus.rs2_read_rob_value, 32'd0);
        check("t6 tag0 ready", 32'(bus.rs2_rob_ready), 32'd0);
        tick();
        bus.rs1_rob_tag = 4'd3;
        bus.rs2_rob_tag = 4'd2;
        @(negedge clock);
        check("t6 stored value", bus.rs1_read_rob_value, 32'h55);
        check("t6 stored ready", 32'(bus.rs1_rob_ready), 32'd1);
        check("t6 pending ready", 32'(bus.rs2_rob_ready), 32'd0);
        tick();

        // Squash with a committable head, then a halt that freezes the ROB.
        alloc(5'd4);
        cdb(4'd1, 32'h11);
        tick();
        bus.squash = 1'b1;
        @(negedge clock);
        check("t7 squash no commit", 32'(bus.commit_valid), 32'd0);
        check("t7 squash no wb", 32'(bus.wb_reg_wr_en_out), 32'd0);
        tick();
        @(negedge clock);
        check("t7 after squash tag", 32'(bus.alloc_tag), 32'd1);
        check("t7 after squash commit", 32'(bus.commit_valid), 32'd0);
        bus.alloc_enable = 1'b1;
        bus.alloc_halt   = 1'b1;
        tick();
        @(negedge clock);
        check("t7 halt commits", 32'(bus.commit_valid), 32'd1);
        check("t7 halt not yet", 32'(bus.halt_out), 32'd0);
        tick();
        @(negedge clock);
        check("t7 halt_out", 32'(bus.halt_out), 32'd1);
        alloc(5'd4);
        tick();
        @(negedge clock);
        check("t7 alloc ignored", 32'(bus.alloc_tag), 32'd2);
        check("t7 no commit", 32'(bus.commit_valid), 32'd0);
        tick();
        tick();
        @(negedge clock);
        check("t7 halt sticky", 32'(bus.halt_out), 32'd1);

        // Reset clears the sticky halt.
        #1 reset = 1'b1;
        #1;
        check("t8 reset halt_out", 32'(bus.halt_out), 32'd0);
        check("t8 reset alloc_tag", 32'(bus.alloc_tag), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
